// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, writer state encoding and colours.
// Used by the rectangle writer and the display-side address generator.
package fb_pkg;

  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fb_wr_state_t;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;

endpackage

// File: rtl/fb_rect_writer_if.sv
// Rectangle command handshake plus frame-buffer port B write bus.
// master = command issuer / BRAM side, slave = the writer.
interface fb_rect_writer_if
  import fb_pkg::*;
#(
  parameter int AW = fb_pkg::ADDR_W,
  parameter int CW = fb_pkg::COLOR_W
);

  logic          start;
  logic [8:0]    x0;
  logic [7:0]    y0;
  logic [8:0]    w;
  logic [7:0]    h;
  logic [CW-1:0] color;
  logic          stall;
  logic          we;
  logic [AW-1:0] addr;
  logic [CW-1:0] din;
  logic          busy;
  logic          done;

  modport slave (
    input  start, x0, y0, w, h, color, stall,
    output we, addr, din, busy, done
  );

  modport master (
    output start, x0, y0, w, h, color, stall,
    input  we, addr, din, busy, done
  );

endinterface

// File: rtl/fb_rect_writer.sv
// Clips a rectangle command to the screen and fills it with one colour,
// one raster-ordered pixel write per unstalled clock on BRAM port B.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int COLOR_W = fb_pkg::COLOR_W
) (
  input  logic            clk,
  input  logic            rst,
  fb_rect_writer_if.slave bus
);

  fb_wr_state_t state_q, state_d;

  logic [8:0]         x0_q;
  logic [7:0]         y0_q;
  logic [8:0]         w_q;
  logic [7:0]         h_q;
  logic [COLOR_W-1:0] color_q;

  logic [9:0]         x_q, x_end_q;
  logic [8:0]         y_q, y_end_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [ADDR_W-1:0]  addr_q;

  logic [9:0]         x_sum;
  logic [8:0]         y_sum;
  logic [9:0]         x_end_c;
  logic [8:0]         y_end_c;
  logic               empty;
  logic [ADDR_W-1:0]  y_ext;
  logic [ADDR_W-1:0]  row_base_c;
  logic [ADDR_W-1:0]  wr_addr;
  logic               x_last;
  logic               y_last;
  logic               we;

  // Sums are one bit wider than the operands so they never wrap
  assign x_sum   = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y0_q} + {1'b0, h_q};
  assign x_end_c = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
  assign y_end_c = (y_sum > 9'(V_RES)) ? 9'(V_RES) : y_sum;

  assign empty = (w_q == 9'd0) || (h_q == 8'd0) ||
                 ({1'b0, x0_q} >= 10'(H_RES)) ||
                 ({1'b0, y0_q} >= 9'(V_RES));

  // y0 * 320 as (y0 << 8) + (y0 << 6)
  assign y_ext      = ADDR_W'(y0_q);
  assign row_base_c = (y_ext << 8) + (y_ext << 6);

  assign wr_addr = row_base_q + ADDR_W'(x_q);
  assign x_last  = (x_q == x_end_q - 10'd1);
  assign y_last  = (y_q == y_end_q - 9'd1);
  assign we      = (state_q == FILL) && !bus.stall;

  assign bus.we   = we;
  assign bus.addr = we ? wr_addr : addr_q;
  assign bus.din  = color_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = SETUP;
      SETUP: state_d = empty ? DONE : FILL;
      FILL:  if (we && x_last && y_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            w_q     <= bus.w;
            h_q     <= bus.h;
            color_q <= bus.color;
          end
        end
        SETUP: begin
          x_end_q    <= x_end_c;
          y_end_q    <= y_end_c;
          row_base_q <= row_base_c;
          x_q        <= {1'b0, x0_q};
          y_q        <= {1'b0, y0_q};
        end
        FILL: begin
          if (we) begin
            addr_q <= wr_addr;
            if (x_last) begin
              x_q        <= {1'b0, x0_q};
              y_q        <= y_q + 9'd1;
              row_base_q <= row_base_q + ADDR_W'(H_RES);
            end else begin
              x_q <= x_q + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed checks for fb_rect_writer: fills, clipping, empty commands,
// stall, reset abort and start-while-busy.
module tb_fb_rect_writer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fb_rect_writer_if bus ();

  fb_rect_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int wr_q[$];
  int din_q[$];
  int done_cyc;
  int n_done;
  int busy_after;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_addrs(input string tag, input int exp[$]);
    check({tag, "_n"}, wr_q.size(), exp.size());
    foreach (exp[i])
      check($sformatf("%s_a%0d", tag, i),
            (i < wr_q.size()) ? wr_q[i] : -1, exp[i]);
  endtask

  // Cycle 1 is the SETUP cycle right after the accepting edge
  task automatic run_cmd(input int x0, input int y0, input int w,
                         input int h, input int color,
                         input int stall_at, input int stall_len,
                         input int restart_at);
    int c;
    wr_q.delete();
    din_q.delete();
    done_cyc   = -1;
    n_done     = 0;
    busy_after = -1;
    @(posedge clk); #1;
    bus.x0    = 9'(x0);
    bus.y0    = 8'(y0);
    bus.w     = 9'(w);
    bus.h     = 8'(h);
    bus.color = 12'(color);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    for (int k = 0; k < 300; k++) begin
      bus.stall = (c >= stall_at) && (c < stall_at + stall_len);
      if (c == restart_at) begin
        bus.start = 1'b1;
        bus.x0    = 9'd100;
        bus.w     = 9'd5;
        bus.h     = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.we) begin
        wr_q.push_back(int'(bus.addr));
        din_q.push_back(int'(bus.din));
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = int'(bus.busy);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    if (done_cyc < 0) check("timeout", 0, 1);
  endtask

  initial begin
    int exp_a[$];
    int extra;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.x0    = '0;
    bus.y0    = '0;
    bus.w     = '0;
    bus.h     = '0;
    bus.color = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_we",   int'(bus.we),   0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_addr", int'(bus.addr), 0);
    check("rst_din",  int'(bus.din),  0);

    // basic 2x2 white at origin
    run_cmd(0, 0, 2, 2, 'hFFF, 0, 0, -1);
    exp_a = '{0, 1, 320, 321};
    check_addrs("basic", exp_a);
    check("basic_din", (din_q.size() > 0) ? din_q[0] : -1, 'hFFF);
    check("basic_din_last", (din_q.size() > 3) ? din_q[3] : -1, 'hFFF);
    check("basic_done_cyc", done_cyc, 6);
    check("basic_n_done", n_done, 1);
    check("basic_busy_after", busy_after, 0);

    // clipped at bottom-right corner
    run_cmd(318, 238, 5, 5, 'h0F0, 0, 0, -1);
    exp_a = '{76478, 76479, 76798, 76799};
    check_addrs("clip", exp_a);
    check("clip_done_cyc", done_cyc, 6);

    // empty: zero width
    run_cmd(5, 5, 0, 3, 'h123, 0, 0, -1);
    check("empty_w_n", wr_q.size(), 0);
    check("empty_w_done_cyc", done_cyc, 2);
    check("empty_w_busy_after", busy_after, 0);

    // empty: x0 off screen
    run_cmd(320, 0, 4, 4, 'h321, 0, 0, -1);
    check("empty_x_n", wr_q.size(), 0);
    check("empty_x_done_cyc", done_cyc, 2);
    check("empty_x_busy_after", busy_after, 0);

    // stall two cycles right after first write (first write in cycle 2)
    run_cmd(10, 5, 3, 1, 'hABC, 3, 2, -1);
    exp_a = '{1610, 1611, 1612};
    check_addrs("stall", exp_a);
    check("stall_done_cyc", done_cyc, 7);
    check("stall_din", (din_q.size() > 2) ? din_q[2] : -1, 'hABC);

    // stall in SETUP has no effect
    run_cmd(0, 1, 1, 1, 'h00F, 1, 1, -1);
    exp_a = '{320};
    check_addrs("setup_stall", exp_a);
    check("setup_stall_done_cyc", done_cyc, 3);

    // start pulsed during FILL is ignored
    run_cmd(0, 0, 2, 2, 'h555, 0, 0, 3);
    exp_a = '{0, 1, 320, 321};
    check_addrs("restart", exp_a);
    check("restart_done_cyc", done_cyc, 6);
    check("restart_n_done", n_done, 1);

    // reset mid-fill of a 4x4 aborts with no further writes or done
    @(posedge clk); #1;
    bus.x0    = 9'd0;
    bus.y0    = 8'd0;
    bus.w     = 9'd4;
    bus.h     = 8'd4;
    bus.color = 12'hF00;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_pre_we", int'(bus.we), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_we",   int'(bus.we),   0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.we || bus.done || bus.busy) extra++;
    end
    check("abort_quiet", extra, 0);

    // single pixel at the last address after recovery
    run_cmd(319, 239, 1, 1, 'hFFF, 0, 0, -1);
    exp_a = '{76799};
    check_addrs("corner", exp_a);
    check("corner_done_cyc", done_cyc, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Frame-buffer write engine that fills an axis-aligned rectangle of the 320x240, 12-bit-colour frame buffer with a single colour. Sits upstream of the dual-port display BRAM. It drives the write port (port B, same clock as the writer), while the display path reads port A through the address generator. Game/UI logic issues one rectangle command at a time through a start/busy/done handshake. The block clips the command to the screen, then emits one pixel write per unstalled cycle.

## Interface
Parameters:
- H_RES, 320: frame-buffer width in pixels
- V_RES, 240: frame-buffer height in pixels
- ADDR_W, 17: frame-buffer address width
- COLOR_W, 12: pixel width, {R,G,B} 4 bits each

Ports:
- clk  in  1  single clock for the whole block; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- x0  in  9  rectangle left column
- y0  in  8  rectangle top row
- w  in  9  width in pixels
- h  in  8  height in pixels
- color  in  COLOR_W  fill colour
- stall  in  1  port B unavailable this cycle; freezes the fill
- we  out  1  frame-buffer write enable
- addr  out  ADDR_W  write address, y*H_RES + x
- din  out  COLOR_W  write data
- busy  out  1  high in SETUP, FILL, DONE
- done  out  1  one-cycle pulse when the command completes

## Operation
- States: IDLE, SETUP, FILL, DONE.
- IDLE:
  - start=1 latches x0, y0, w, h and color, then goes to SETUP.
  - start in any other state is ignored; commands are not queued.
- SETUP:
  - Clipping:
    - x_end = min(x0+w, H_RES), computed in 10 bits.
    - y_end = min(y0+h, V_RES), computed in 9 bits.
  - Empty rectangle goes straight to DONE with no writes. Empty means w=0, h=0, x0>=H_RES or y0>=V_RES.
  - Otherwise goes to FILL with:
    - row_base = y0*H_RES, formed by shift-add (y0<<8)+(y0<<6); no multiplier.
    - x = x0, y = y0.
- FILL:
  - Each cycle with stall=0:
    - Write is issued at addr = row_base + x.
    - x increments.
    - At x = x_end-1: x reloads x0, y increments, row_base += H_RES.
    - The write at (x_end-1, y_end-1) is the last; next state is DONE.
  - Cycles with stall=1: we=0 and all counters hold.
- DONE:
  - done=1 for one cycle, then IDLE.
- Outputs:
  - we = (state==FILL) && !stall.
  - addr and din are valid whenever we=1. Otherwise they hold their last value.
  - din = latched color.
- Scan order is raster: left to right, top to bottom. Each pixel of the clipped rectangle is written exactly once.
- Reset values: state IDLE; we=0, busy=0, done=0, addr=0, din=0.
- rst mid-command aborts it. No write is issued in any cycle following the reset edge, and no done pulse is produced.

## Timing
- Command accepted at edge N: SETUP during cycle N..N+1. First we=1 in the cycle after edge N+1.
- Unstalled fill: we high for exactly Wc*Hc consecutive cycles, where Wc and Hc are the clipped width and height.
- done is high in the cycle immediately after the last write.
- busy falls together with the end of done. The earliest next accepted start is at the edge that ends done+1, i.e. while IDLE.
- Empty command: done high in the cycle after SETUP, i.e. 2 cycles after acceptance.
- Each stall cycle adds exactly one cycle to the total. A stall asserted in SETUP or DONE has no effect.
- Throughput: 1 pixel/clock. A full-screen fill takes 76800 + 2 cycles unstalled.
- No address arithmetic exceeds ADDR_W. The maximum address is 76799.

## Structure
- Shared package fb_pkg holds:
  - H_RES, V_RES, ADDR_W, COLOR_W
  - the state enumeration fb_wr_state_t {IDLE, SETUP, FILL, DONE}
  - the common colour constants (black 12'h000, white 12'hFFF)
- The display-side address generator uses the same fb_pkg constants.
- Single module; clipping and the row-base shift-add are inlined in SETUP. No sub-module is required.

## Test plan
- Basic fill: x0=0, y0=0, w=2, h=2, color=12'hFFF.
  - we high for 4 cycles with addr 0, 1, 320, 321 and din FFF.
  - done on the 5th cycle after first we.
- Clipping: x0=318, y0=238, w=5, h=5.
  - Exactly 4 writes: addr 76478, 76479, 76798, 76799.
- Empty commands: w=0; and separately x0=320.
  - No we; done exactly 2 cycles after start acceptance; busy low the cycle after.
- Stall: x0=10, y0=5, w=3, h=1.
  - stall high for 2 cycles after the first write.
  - Addresses are 1610, 1611, 1612 with no repeat or skip; done is delayed by exactly 2 cycles.
- Reset and start while busy:
  - rst pulsed mid-fill of a 4x4: we=0 from the next cycle, busy=0, no done.
  - start pulsed during FILL is ignored; the write count equals that of the first command only.
